cksum_arbiter: RTL and testbench

- Shares one checksum unit among NUM_REQ executor lanes.
- Latches one-cycle checksum requests from each lane and grants them round-robin.
- Drives the checksum unit's start/field/header inputs from the granted lane and routes the result back with a one-cycle ready pulse.
- Sits between N executor instances and a single cksum instance.

---
 rtl/cksum_arbiter_pkg.sv | 14 +
 rtl/cksum_arbiter_if.sv | 40 ++++
 rtl/cksum_arbiter_rr_picker.sv | 26 ++
 rtl/cksum_arbiter.sv | 123 ++++++++++++
 tb/tb_cksum_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cksum_arbiter_pkg.sv
// Shared types and bus widths for the checksum arbiter slice.
package cksum_arbiter_pkg;
    localparam int NUM_REQ_DEF = 4;
    localparam int BYTE_W      = 8;
    localparam int HALF_W      = 16;
    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 8;
    localparam int HDR_MAX_LEN = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_e;
endpackage

// File: rtl/cksum_arbiter_if.sv
// Lane-side request bus and checksum-unit bus used by the arbiter.
interface cksum_arbiter_if
    import cksum_arbiter_pkg::*;
    #(parameter int NUM_REQ = NUM_REQ_DEF);
    logic [NUM_REQ-1:0]                               req_start_i;
    logic [NUM_REQ-1:0][HDR_MAX_LEN-1:0][BYTE_W-1:0]  req_pkt_hdr_i;
    logic [NUM_REQ-1:0][ADDR_W-1:0]                   req_field_start_i;
    logic [NUM_REQ-1:0][DATA_W-1:0]                   req_field_len_i;
    logic [NUM_REQ-1:0]                               req_ready_o;
    logic [HALF_W-1:0]                                req_cksum_val_o;

    modport master (
        output req_start_i, req_pkt_hdr_i, req_field_start_i, req_field_len_i,
        input  req_ready_o, req_cksum_val_o
    );
    modport slave (
        input  req_start_i, req_pkt_hdr_i, req_field_start_i, req_field_len_i,
        output req_ready_o, req_cksum_val_o
    );
endinterface

interface cksum_cu_if
    import cksum_arbiter_pkg::*;
    ;
    logic                               cu_start_o;
    logic [HDR_MAX_LEN-1:0][BYTE_W-1:0] cu_pkt_hdr_o;
    logic [ADDR_W-1:0]                  cu_field_start_o;
    logic [DATA_W-1:0]                  cu_field_len_o;
    logic                               cu_ready_i;
    logic [HALF_W-1:0]                  cu_val_i;

    modport master (
        output cu_start_o, cu_pkt_hdr_o, cu_field_start_o, cu_field_len_o,
        input  cu_ready_i, cu_val_i
    );
    modport slave (
        input  cu_start_o, cu_pkt_hdr_o, cu_field_start_o, cu_field_len_o,
        output cu_ready_i, cu_val_i
    );
endinterface

// File: rtl/cksum_arbiter_rr_picker.sv
// Combinational round-robin pick: first set pending bit at or after ptr_i, with wrap.
module cksum_arbiter_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pending_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);
    logic [IDX_W-1:0] cand_idx;

    // Scan offsets from far to near so the closest set bit is written last.
    always_comb begin
        found_o  = 1'b0;
        idx_o    = '0;
        cand_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand_idx = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
            if (pending_i[cand_idx]) begin
                found_o = 1'b1;
                idx_o   = cand_idx;
            end
        end
    end
endmodule

// File: rtl/cksum_arbiter.sv
// Round-robin arbiter sharing one checksum unit among NUM_REQ executor lanes.
module cksum_arbiter
    import cksum_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    cksum_arbiter_if.slave     req,
    cksum_cu_if.master         cu,
    output logic [NUM_REQ-1:0] pending_o,
    output logic               overrun_o
);
    arb_state_e                     state_q, state_d;
    logic [IDX_W-1:0]               grant_q, grant_d;
    logic [IDX_W-1:0]               rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]             pending_q, pending_d;
    logic                           overrun_q, overrun_d;
    logic [NUM_REQ-1:0][ADDR_W-1:0] fstart_q, fstart_d;
    logic [NUM_REQ-1:0][DATA_W-1:0] flen_q, flen_d;
    logic                           cu_start_q, cu_start_d;
    logic [ADDR_W-1:0]              cu_fstart_q, cu_fstart_d;
    logic [DATA_W-1:0]              cu_flen_q, cu_flen_d;
    logic [NUM_REQ-1:0]             ready_q, ready_d;
    logic [HALF_W-1:0]              val_q, val_d;

    logic                           found;
    logic [IDX_W-1:0]               win_idx;
    logic                           done;
    logic [NUM_REQ-1:0]             clear, accept, overrun_hit;

    assign done = (state_q == ST_WAIT) && cu.cu_ready_i;

    cksum_arbiter_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
        .pending_i (pending_q),
        .ptr_i     (rr_ptr_q),
        .found_o   (found),
        .idx_o     (win_idx)
    );

    // A start landing on the lane's own completion edge is accepted (set wins).
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        always_comb begin
            clear[gi]       = done && (grant_q == IDX_W'(gi));
            accept[gi]      = req.req_start_i[gi] && (!pending_q[gi] || clear[gi]);
            overrun_hit[gi] = req.req_start_i[gi] && pending_q[gi] && !clear[gi];
            pending_d[gi]   = accept[gi] || (pending_q[gi] && !clear[gi]);
            fstart_d[gi]    = accept[gi] ? req.req_field_start_i[gi] : fstart_q[gi];
            flen_d[gi]      = accept[gi] ? req.req_field_len_i[gi]   : flen_q[gi];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            pending_q   <= '0;
            overrun_q   <= 1'b0;
            fstart_q    <= '0;
            flen_q      <= '0;
            cu_start_q  <= 1'b0;
            cu_fstart_q <= '0;
            cu_flen_q   <= '0;
            ready_q     <= '0;
            val_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            fstart_q    <= fstart_d;
            flen_q      <= flen_d;
            cu_start_q  <= cu_start_d;
            cu_fstart_q <= cu_fstart_d;
            cu_flen_q   <= cu_flen_d;
            ready_q     <= ready_d;
            val_q       <= val_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (found) state_d = ST_WAIT;
            ST_WAIT: if (done)  state_d = ST_IDLE;
            default:            state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        cu_start_d  = 1'b0;
        cu_fstart_d = cu_fstart_q;
        cu_flen_d   = cu_flen_q;
        ready_d     = '0;
        val_d       = val_q;
        overrun_d   = overrun_q | (|overrun_hit);
        if (state_q == ST_IDLE && found) begin
            grant_d     = win_idx;
            cu_start_d  = 1'b1;
            cu_fstart_d = fstart_q[win_idx];
            cu_flen_d   = flen_q[win_idx];
        end
        if (done) begin
            ready_d[grant_q] = 1'b1;
            val_d            = cu.cu_val_i;
            rr_ptr_d         = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
    end

    assign pending_o            = pending_q;
    assign overrun_o            = overrun_q;
    assign req.req_ready_o      = ready_q;
    assign req.req_cksum_val_o  = val_q;
    assign cu.cu_start_o        = cu_start_q;
    assign cu.cu_field_start_o  = cu_fstart_q;
    assign cu.cu_field_len_o    = cu_flen_q;
    assign cu.cu_pkt_hdr_o      = req.req_pkt_hdr_i[grant_q];
endmodule

// File: tb/tb_cksum_arbiter.sv
// Scoreboard bench: a checksum-unit model and a ready monitor check grants against queued expectations.
module tb_cksum_arbiter;
    import cksum_arbiter_pkg::*;
    localparam int N = 4;

    typedef struct {
        int          lane;
        logic [7:0]  fs;
        logic [7:0]  fl;
        logic [15:0] val;
        int          delay;
        bit          respond;
        bit          restart;
    } cu_exp_t;

    typedef struct {
        int          lane;
        logic [15:0] val;
    } rdy_exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] stim_start = '0;
    logic [N-1:0] restart_start = '0;
    logic [N-1:0] pending;
    logic         overrun;

    cu_exp_t  cu_q[$];
    rdy_exp_t rdy_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cksum_arbiter_if #(.NUM_REQ(N)) req_bus();
    cksum_cu_if                     cu_bus();

    assign req_bus.req_start_i = stim_start | restart_start;

    cksum_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req_bus),
        .cu        (cu_bus),
        .pending_o (pending),
        .overrun_o (overrun)
    );

    function automatic logic [63:0] hdr_of(int lane);
        logic [63:0] h;
        for (int b = 0; b < 8; b++) h[b*8 +: 8] = 8'(lane * 16 + b);
        return h;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_lane(int lane, int fs, int fl);
        req_bus.req_field_start_i[lane] = 8'(fs);
        req_bus.req_field_len_i[lane]   = 8'(fl);
    endtask

    task automatic pulse(logic [N-1:0] mask);
        @(posedge clk); #1 stim_start = mask;
        @(posedge clk); #1 stim_start = '0;
    endtask

    task automatic expect_grant(int lane, int fs, int fl, logic [15:0] val, int delay,
                                bit respond, bit restart);
        cu_exp_t  c;
        rdy_exp_t r;
        c.lane = lane; c.fs = 8'(fs); c.fl = 8'(fl); c.val = val;
        c.delay = delay; c.respond = respond; c.restart = restart;
        cu_q.push_back(c);
        if (respond) begin
            r.lane = lane; r.val = val;
            rdy_q.push_back(r);
        end
    endtask

    task automatic drain(string name);
        int n;
        n = 0;
        while ((cu_q.size() != 0 || rdy_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_timeout: got %0d/%0d queued expected 0/0", name, cu_q.size(), rdy_q.size());
            cu_q.delete();
            rdy_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #3 rst = 1'b0;
    endtask

    // Checksum unit model: verifies each start, then answers after the queued delay.
    initial begin
        cu_exp_t e;
        cu_bus.cu_ready_i = 1'b0;
        cu_bus.cu_val_i   = '0;
        forever begin
            @(negedge clk);
            if (!rst && cu_bus.cu_start_o) begin
                if (cu_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_cu_start: got start with fs %0d expected no start",
                             cu_bus.cu_field_start_o);
                end else begin
                    e = cu_q.pop_front();
                    $display("cu_start lane %0d fs %0d fl %0d", e.lane,
                             cu_bus.cu_field_start_o, cu_bus.cu_field_len_o);
                    check("cu_field_start", 64'(cu_bus.cu_field_start_o), 64'(e.fs));
                    check("cu_field_len", 64'(cu_bus.cu_field_len_o), 64'(e.fl));
                    check("cu_pkt_hdr", cu_bus.cu_pkt_hdr_o, hdr_of(e.lane));
                    @(negedge clk);
                    check("cu_start_width", 64'(cu_bus.cu_start_o), 64'(0));
                    if (e.respond) begin
                        repeat (e.delay) @(posedge clk);
                        #1;
                        cu_bus.cu_ready_i = 1'b1;
                        cu_bus.cu_val_i   = e.val;
                        if (e.restart) restart_start = N'(1);
                        @(posedge clk); #1;
                        cu_bus.cu_ready_i = 1'b0;
                        restart_start     = '0;
                    end
                end
            end
        end
    end

    // Ready monitor: every ready pulse must match the next queued response.
    initial begin
        rdy_exp_t r;
        forever begin
            @(negedge clk);
            if (!rst && req_bus.req_ready_o != '0) begin
                if (rdy_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ready: got %b expected 0000", req_bus.req_ready_o);
                end else begin
                    r = rdy_q.pop_front();
                    $display("ready lane %0d val %h", r.lane, req_bus.req_cksum_val_o);
                    check("ready_mask", 64'(req_bus.req_ready_o), 64'(1) << r.lane);
                    check("cksum_val", 64'(req_bus.req_cksum_val_o), 64'(r.val));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int k = 0; k < N; k++) begin
            req_bus.req_pkt_hdr_i[k] = hdr_of(k);
            set_lane(k, 0, 0);
        end
        #2;
        check("rst_pending", 64'(pending), 64'(0));
        check("rst_overrun", 64'(overrun), 64'(0));
        check("rst_cu_start", 64'(cu_bus.cu_start_o), 64'(0));
        check("rst_ready", 64'(req_bus.req_ready_o), 64'(0));
        check("rst_val", 64'(req_bus.req_cksum_val_o), 64'(0));
        #10 rst = 1'b0;

        // Single lane 0
        set_lane(0, 14, 20);
        expect_grant(0, 14, 20, 16'hB861, 2, 1'b1, 1'b0);
        pulse(4'b0001);
        check("t1_pending_set", 64'(pending), 64'(1));
        drain("t1");
        check("t1_pending_clear", 64'(pending), 64'(0));

        // All four lanes at once from rr_ptr 0
        do_reset();
        for (int k = 0; k < N; k++) begin
            set_lane(k, 10 + k, 30 + k);
            expect_grant(k, 10 + k, 30 + k, 16'(16'h1111 * (k + 1)), k % 3, 1'b1, 1'b0);
        end
        pulse(4'b1111);
        drain("t2");
        // rr_ptr wrapped to 0: lane 0 beats lane 3
        set_lane(0, 1, 2);
        set_lane(3, 3, 4);
        expect_grant(0, 1, 2, 16'h0A0A, 1, 1'b1, 1'b0);
        expect_grant(3, 3, 4, 16'h0B0B, 1, 1'b1, 1'b0);
        pulse(4'b1001);
        drain("t2_wrap");

        // Lane 2 alone, then lanes 1 and 3 together: 3 first
        set_lane(2, 22, 23);
        expect_grant(2, 22, 23, 16'h2222, 1, 1'b1, 1'b0);
        pulse(4'b0100);
        drain("t3a");
        set_lane(1, 11, 12);
        set_lane(3, 33, 34);
        expect_grant(3, 33, 34, 16'h3333, 1, 1'b1, 1'b0);
        expect_grant(1, 11, 12, 16'h1111, 1, 1'b1, 1'b0);
        pulse(4'b1010);
        drain("t3b");

        // Overrun on lane 1
        set_lane(1, 40, 8);
        expect_grant(1, 40, 8, 16'hABCD, 3, 1'b1, 1'b0);
        pulse(4'b0010);
        set_lane(1, 99, 77);
        pulse(4'b0010);
        @(negedge clk);
        check("t4_overrun_set", 64'(overrun), 64'(1));
        drain("t4");
        check("t4_overrun_sticky", 64'(overrun), 64'(1));
        check("t4_pending_clear", 64'(pending), 64'(0));

        // Restart on the ready edge of lane 0
        do_reset();
        check("t5_overrun_cleared", 64'(overrun), 64'(0));
        set_lane(0, 5, 6);
        expect_grant(0, 5, 6, 16'h0F0F, 1, 1'b1, 1'b1);
        expect_grant(0, 50, 60, 16'hF0F0, 1, 1'b1, 1'b0);
        pulse(4'b0001);
        set_lane(0, 50, 60);
        n = 0;
        while (req_bus.req_ready_o[0] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t5_ready_seen", 64'(n < 100), 64'(1));
        check("t5_pending_kept", 64'(pending[0]), 64'(1));
        drain("t5");
        check("t5_pending_clear", 64'(pending), 64'(0));
        check("t5_no_overrun", 64'(overrun), 64'(0));

        // Asynchronous reset during WAIT
        set_lane(2, 7, 9);
        expect_grant(2, 7, 9, 16'h0, 0, 1'b0, 1'b0);
        pulse(4'b0100);
        n = 0;
        while (cu_bus.cu_start_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t6_start_seen", 64'(n < 50), 64'(1));
        @(posedge clk); #3 rst = 1'b1;
        #1;
        check("t6_rst_pending", 64'(pending), 64'(0));
        check("t6_rst_field_start", 64'(cu_bus.cu_field_start_o), 64'(0));
        check("t6_rst_field_len", 64'(cu_bus.cu_field_len_o), 64'(0));
        check("t6_rst_val", 64'(req_bus.req_cksum_val_o), 64'(0));
        check("t6_rst_cu_start", 64'(cu_bus.cu_start_o), 64'(0));
        #2 rst = 1'b0;
        repeat (20) @(negedge clk);
        check("t6_idle_pending", 64'(pending), 64'(0));
        cu_q.delete();
        set_lane(1, 3, 4);
        expect_grant(1, 3, 4, 16'h1234, 2, 1'b1, 1'b0);
        pulse(4'b0010);
        drain("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
